alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have parameter MUL_EN, default 1: 1 = MUL opcode executes; 0 = MUL opcode is treated as illegal.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-004 The block SHALL have port issue_valid  input  1  upstream holds a valid operation.
REQ-005 The block SHALL have port issue_ready  output  1  the block can accept an operation this cycle.
REQ-006 The block SHALL have port opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1 (rs1<<1), 110 MUL (low byte), 111 illegal.
REQ-007 The block SHALL have port rd_addr  input  2  destination register index.
REQ-008 The block SHALL have port rs1_data  input  8  source operand 1 from the register file read port.
REQ-009 The block SHALL have port rs2_data  input  8  source operand 2 from the register file read port.
REQ-010 The block SHALL have port reg_wr_en  output  1  one-cycle write strobe to the register file.
REQ-011 The block SHALL have port wr_addr  output  2  register file write address.
REQ-012 The block SHALL have port wr_data  output  8  register file write data.
REQ-013 The block SHALL have port zero_flag  output  1  last written result == 0.
REQ-014 The block SHALL have port carry_flag  output  1  carry/borrow/overflow of last written result.
REQ-015 The block SHALL have port illegal_op  output  1  one-cycle pulse when an illegal opcode is retired.

Function
REQ-016 The FSM SHALL have states IDLE, MUL, WB.
REQ-017 Acceptance SHALL occur on a rising edge where issue_valid=1 and issue_ready=1; issue_ready SHALL be 1 in IDLE and WB and 0 in MUL.
REQ-018 On acceptance, opcode, rd_addr, rs1_data and rs2_data SHALL be captured; later changes to these inputs SHALL NOT affect the accepted operation.
REQ-019 Single-cycle ops (ADD..SHL1, illegal) accepted at edge N SHALL move to WB, with reg_wr_en=1 during the cycle after edge N (latency 1).
REQ-020 MUL accepted at edge N SHALL enter MUL and perform 8 shift-add iterations at edges N+1..N+8, then enter WB, with reg_wr_en high during the cycle after edge N+8 (latency 9).
REQ-021 In WB, reg_wr_en SHALL be high for exactly one cycle with wr_addr = captured rd_addr and wr_data = result; reg_wr_en SHALL be low in every other state.
REQ-022 An acceptance during WB SHALL be legal; the next state SHALL be WB (single-cycle op) or MUL, giving one single-cycle op retired per cycle back-to-back.
REQ-023 WB with no acceptance SHALL return to IDLE.
REQ-024 All arithmetic SHALL be modulo 256.
REQ-025 carry_flag SHALL be: ADD = bit 8 of the 9-bit sum; SUB = 1 when rs1 < rs2 (unsigned borrow); SHL1 = rs1[7]; MUL = 1 when the 16-bit product's high byte != 0; AND/OR/XOR = 0.
REQ-026 zero_flag and carry_flag SHALL update only on the edge that ends a WB cycle with reg_wr_en=1, and SHALL hold otherwise.
REQ-027 An illegal opcode (111, or 110 when MUL_EN=0) SHALL pass through WB with reg_wr_en=0 and illegal_op=1 for that cycle, and flags SHALL be unchanged.
REQ-028 wr_addr and wr_data SHALL hold their last values outside WB.

Reset
REQ-029 When reset=0, the state SHALL go to IDLE and reg_wr_en, illegal_op, zero_flag, carry_flag, wr_addr and wr_data SHALL be 0, with issue_ready=1 after release.
REQ-030 A reset asserted mid-MUL or during WB SHALL abort the operation with no write strobe issued.

Verification
REQ-031 ADD rs1=0xFF, rs2=0x01, rd=2 -> next cycle reg_wr_en=1, wr_addr=2, wr_data=0x00; then zero_flag=1, carry_flag=1.
REQ-032 SUB rs1=0x03, rs2=0x05 -> wr_data=0xFE, carry_flag=1, zero_flag=0.
REQ-033 MUL rs1=0x12, rs2=0x10 -> issue_ready=0 for 8 cycles, write strobe 9 cycles after accept, wr_data=0x20, carry_flag=1.
REQ-034 Back-to-back XOR 0xAA^0x55 then OR 0x00|0x00 with issue_valid held -> strobes on two consecutive cycles, wr_data=0xFF then 0x00.
REQ-035 Opcode 111 -> illegal_op pulse, no reg_wr_en, flags unchanged; with MUL_EN=0, opcode 110 -> same response.
REQ-036 reset=0 at the 4th MUL iteration -> no reg_wr_en pulse, all outputs 0, next ADD after release completes normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// 8-bit ALU execute stage writing one register-file result per retired op; latency 1 cycle, MUL 9 cycles.
// Backpressure: issue_ready drops only while the shift-add multiplier iterates; WB accepts back-to-back.
module alu_exec_stage #(
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [2:0] opcode,
    input  logic [1:0] rd_addr,
    input  logic [7:0] rs1_data,
    input  logic [7:0] rs2_data,
    output logic       reg_wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic       illegal_op
);

    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;
    logic        carry_pend_q, carry_pend_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic        accept;
    logic        is_mul_op;
    logic        op_illegal;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic [15:0] prod_step;

    assign issue_ready = (state_q != MUL);
    assign accept      = issue_valid && issue_ready;
    assign is_mul_op   = (opcode == 3'b110) && (MUL_EN != 0);
    assign op_illegal  = (opcode == 3'b111) || ((opcode == 3'b110) && (MUL_EN == 0));
    assign sum9        = {1'b0, rs1_data} + {1'b0, rs2_data};
    assign prod_step   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        case (opcode)
            3'b000: begin
                alu_res   = sum9[7:0];
                alu_carry = sum9[8];
            end
            3'b001: begin
                alu_res   = rs1_data - rs2_data;
                alu_carry = (rs1_data < rs2_data);
            end
            3'b010: alu_res = rs1_data & rs2_data;
            3'b011: alu_res = rs1_data | rs2_data;
            3'b100: alu_res = rs1_data ^ rs2_data;
            3'b101: begin
                alu_res   = {rs1_data[6:0], 1'b0};
                alu_carry = rs1_data[7];
            end
            default: begin
                alu_res   = 8'h00;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        illegal_d    = illegal_q;
        carry_pend_d = carry_pend_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        zero_d       = zero_q;
        carry_d      = carry_q;

        case (state_q)
            MUL: begin
                prod_d   = prod_step;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d      = WB;
                    illegal_d    = 1'b0;
                    wr_addr_d    = rd_q;
                    wr_data_d    = prod_step[7:0];
                    carry_pend_d = (prod_step[15:8] != 8'h00);
                end
            end
            default: begin
                // Flags commit at the end of a legal WB cycle, from the value being written.
                if (state_q == WB) begin
                    state_d = IDLE;
                    if (!illegal_q) begin
                        zero_d  = (wr_data_q == 8'h00);
                        carry_d = carry_pend_q;
                    end
                end
                if (accept) begin
                    if (is_mul_op) begin
                        state_d  = MUL;
                        rd_d     = rd_addr;
                        mcand_d  = {8'h00, rs1_data};
                        mplier_d = rs2_data;
                        prod_d   = 16'h0000;
                        cnt_d    = 3'd0;
                    end else begin
                        state_d   = WB;
                        illegal_d = op_illegal;
                        if (!op_illegal) begin
                            wr_addr_d    = rd_addr;
                            wr_data_d    = alu_res;
                            carry_pend_d = alu_carry;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rd_q         <= 2'd0;
            illegal_q    <= 1'b0;
            carry_pend_q <= 1'b0;
            mcand_q      <= 16'h0000;
            mplier_q     <= 8'h00;
            prod_q       <= 16'h0000;
            cnt_q        <= 3'd0;
            wr_addr_q    <= 2'd0;
            wr_data_q    <= 8'h00;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            illegal_q    <= illegal_d;
            carry_pend_q <= carry_pend_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
        end
    end

    assign reg_wr_en  = (state_q == WB) && !illegal_q;
    assign illegal_op = (state_q == WB) && illegal_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench: u1 has the multiplier enabled, u0 treats MUL as illegal; both see the same stimulus.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issue_valid = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rs1_data = 8'h00;
    logic [7:0] rs2_data = 8'h00;

    logic       rdy1, wen1, z1, c1, ill1;
    logic [1:0] wa1;
    logic [7:0] wd1;
    logic       rdy0, wen0, z0, c0, ill0;
    logic [1:0] wa0;
    logic [7:0] wd0;

    int n_chk  = 0;
    int n_fail = 0;
    int strobes;

    always #5 clk = ~clk;

    alu_exec_stage #(.MUL_EN(1)) u1 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(rdy1),
        .opcode(opcode), .rd_addr(rd_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_wr_en(wen1), .wr_addr(wa1), .wr_data(wd1),
        .zero_flag(z1), .carry_flag(c1), .illegal_op(ill1)
    );

    alu_exec_stage #(.MUL_EN(0)) u0 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(rdy0),
        .opcode(opcode), .rd_addr(rd_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_wr_en(wen0), .wr_addr(wa0), .wr_data(wd0),
        .zero_flag(z0), .carry_flag(c0), .illegal_op(ill0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one op for a single accepting edge, then scrambles the inputs.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        opcode      = op;
        rd_addr     = rd;
        rs1_data    = a;
        rs2_data    = b;
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        opcode      = 3'b011;
        rd_addr     = 2'd0;
        rs1_data    = 8'h77;
        rs2_data    = 8'h99;
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", {rdy1, wen1, ill1, z1, c1, wa1, wd1}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00});
        @(negedge clk);
        reset = 1'b1;

        // ADD 0xFF + 0x01 -> 0x00 with carry
        issue(3'b000, 2'd2, 8'hFF, 8'h01);
        @(negedge clk);
        chk("add_strobe", {wen1, ill1, wa1, wd1}, {1'b1, 1'b0, 2'd2, 8'h00});
        @(negedge clk);
        chk("add_flags", {z1, c1}, {1'b1, 1'b1});
        chk("add_after", {wen1, wa1, wd1, rdy1}, {1'b0, 2'd2, 8'h00, 1'b1});

        // SUB 0x03 - 0x05 -> 0xFE with borrow
        issue(3'b001, 2'd1, 8'h03, 8'h05);
        @(negedge clk);
        chk("sub_strobe", {wen1, wa1, wd1}, {1'b1, 2'd1, 8'hFE});
        @(negedge clk);
        chk("sub_flags", {z1, c1}, {1'b0, 1'b1});

        // MUL 0x12 * 0x10 = 0x120: busy 8 cycles, outputs hold the SUB write
        issue(3'b110, 2'd3, 8'h12, 8'h10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy", {rdy1, wen1, wa1, wd1}, {1'b0, 1'b0, 2'd1, 8'hFE});
        end
        @(negedge clk);
        chk("mul_strobe", {rdy1, wen1, wa1, wd1}, {1'b1, 1'b1, 2'd3, 8'h20});
        @(negedge clk);
        chk("mul_flags", {wen1, z1, c1}, {1'b0, 1'b0, 1'b1});

        // Back-to-back XOR then OR with valid held across the WB cycle
        @(negedge clk);
        opcode = 3'b100; rd_addr = 2'd0; rs1_data = 8'hAA; rs2_data = 8'h55;
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        opcode = 3'b011; rd_addr = 2'd1; rs1_data = 8'h00; rs2_data = 8'h00;
        @(negedge clk);
        chk("b2b_xor", {wen1, rdy1, wa1, wd1}, {1'b1, 1'b1, 2'd0, 8'hFF});
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        rs1_data = 8'h5A;
        @(negedge clk);
        chk("b2b_or", {wen1, wa1, wd1}, {1'b1, 2'd1, 8'h00});
        chk("b2b_xor_flags", {z1, c1}, {1'b0, 1'b0});
        @(negedge clk);
        chk("b2b_end", {wen1, z1, c1}, {1'b0, 1'b1, 1'b0});

        // Opcode 111: illegal pulse, no write, flags and write port untouched
        issue(3'b111, 2'd3, 8'hFF, 8'h02);
        @(negedge clk);
        chk("ill_pulse", {ill1, wen1, wa1, wd1}, {1'b1, 1'b0, 2'd1, 8'h00});
        @(negedge clk);
        chk("ill_after", {ill1, wen1, z1, c1}, {1'b0, 1'b0, 1'b1, 1'b0});

        // Opcode 110: illegal on u0, a real multiply on u1 (0xFF*0x02 = 0x1FE)
        issue(3'b110, 2'd2, 8'hFF, 8'h02);
        @(negedge clk);
        chk("mul_dis_pulse", {ill0, wen0, rdy0, rdy1}, {1'b1, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        chk("mul_dis_flags", {ill0, wen0, z0, c0}, {1'b0, 1'b0, 1'b1, 1'b0});
        repeat (7) @(negedge clk);
        chk("mul2_strobe", {wen1, wa1, wd1}, {1'b1, 2'd2, 8'hFE});
        @(negedge clk);
        chk("mul2_flags", {z1, c1}, {1'b0, 1'b1});

        // Reset before the 4th multiply iteration aborts with no strobe
        issue(3'b110, 2'd1, 8'h12, 8'h10);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_mul", {wen1, ill1, z1, c1, wa1, wd1, rdy1}, {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wen1) strobes++;
        end
        chk("rst_no_strobe", strobes, 0);

        // ADD 0x80 + 0x80 after release
        issue(3'b000, 2'd3, 8'h80, 8'h80);
        @(negedge clk);
        chk("post_rst_add", {wen1, wa1, wd1}, {1'b1, 2'd3, 8'h00});
        @(negedge clk);
        chk("post_rst_flags", {wen1, z1, c1}, {1'b0, 1'b1, 1'b1});

        // SHL1 0x81 -> 0x02 with carry out of bit 7
        issue(3'b101, 2'd0, 8'h81, 8'h00);
        @(negedge clk);
        chk("shl_strobe", {wen1, wa1, wd1}, {1'b1, 2'd0, 8'h02});
        @(negedge clk);
        chk("shl_flags", {z1, c1}, {1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
